// File: rtl/sub_bytes_sequencer_if.sv
// Handshake bundle between an upstream producer, the sub-bytes sequencer and its consumer.
// The "slave" modport is the sequencer's view; "master" is the surrounding logic's view.
interface sub_bytes_sequencer_if #(
    parameter int NB_BYTE = 8,
    parameter int N_BYTES = 16
);
    logic [N_BYTES*NB_BYTE-1:0] i_state;
    logic                       i_valid;
    logic                       o_ready;
    logic [N_BYTES*NB_BYTE-1:0] o_state;
    logic                       o_valid;
    logic                       i_ready;
    logic                       o_busy;

    modport master (
        output i_state, i_valid, i_ready,
        input  o_ready, o_state, o_valid, o_busy
    );

    modport slave (
        input  i_state, i_valid, i_ready,
        output o_ready, o_state, o_valid, o_busy
    );
endinterface

// File: rtl/sub_bytes_sequencer.sv
// AES SubBytes over a full state word, time-multiplexed through N_LANES S-box lanes.
// The S-box is computed algebraically (GF(2^8) inverse followed by the affine map).
module byte_substitution_algorithm #(
    parameter int NB_BYTE           = 8,
    parameter int CREATE_OUTPUT_REG = 0
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_byte,
    input  logic               i_valid,
    output logic [NB_BYTE-1:0] o_byte,
    output logic               o_valid
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0]  v;
        logic [15:0] d;
        v = gf_inv(x);
        d = {v, v};
        return v ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    endfunction

    generate
        if (CREATE_OUTPUT_REG != 0) begin : g_reg
            always_ff @(posedge i_clock or posedge i_reset) begin
                if (i_reset) begin
                    o_byte  <= '0;
                    o_valid <= 1'b0;
                end else begin
                    o_byte  <= sbox(i_byte);
                    o_valid <= i_valid;
                end
            end
        end else begin : g_comb
            assign o_byte  = sbox(i_byte);
            assign o_valid = i_valid;
            wire unused_ok = &{1'b0, i_clock, i_reset};
        end
    endgenerate
endmodule

module sub_bytes_sequencer #(
    parameter int NB_BYTE = 8,
    parameter int N_BYTES = 16,
    parameter int N_LANES = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    sub_bytes_sequencer_if.slave   bus
);
    localparam int N_BEATS = N_BYTES / N_LANES;
    localparam int BEAT_W  = $clog2(N_BEATS);
    localparam int W       = N_BYTES * NB_BYTE;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg;
    logic [BEAT_W-1:0]   beat_reg;
    logic [W-1:0]        in_reg;
    logic [W-1:0]        result_reg;

    logic [NB_BYTE-1:0]  lane_in  [N_LANES];
    logic [NB_BYTE-1:0]  lane_out [N_LANES];
    logic [N_LANES-1:0]  lane_valid_unused;
    logic                lane_en;
    logic                accept;

    assign lane_en     = (state_reg == RUN);
    assign bus.o_ready = (state_reg == IDLE) || ((state_reg == DONE) && bus.i_ready);
    assign accept      = bus.i_valid && bus.o_ready;
    assign bus.o_valid = (state_reg == DONE);
    assign bus.o_busy  = (state_reg == RUN);
    assign bus.o_state = result_reg;

    // Lane gi always works on byte beat*N_LANES+gi of the latched word.
    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            assign lane_in[gi] = in_reg[(int'(beat_reg) * N_LANES + gi) * NB_BYTE +: NB_BYTE];

            byte_substitution_algorithm #(
                .NB_BYTE           (NB_BYTE),
                .CREATE_OUTPUT_REG (0)
            ) u_sbox (
                .i_clock (i_clock),
                .i_reset (i_reset),
                .i_byte  (lane_in[gi]),
                .i_valid (lane_en),
                .o_byte  (lane_out[gi]),
                .o_valid (lane_valid_unused[gi])
            );
        end
    endgenerate

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_reg  <= IDLE;
            beat_reg   <= '0;
            in_reg     <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        in_reg    <= bus.i_state;
                        beat_reg  <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    for (int j = 0; j < N_LANES; j++) begin
                        result_reg[(int'(beat_reg) * N_LANES + j) * NB_BYTE +: NB_BYTE] <= lane_out[j];
                    end
                    if (beat_reg == LAST_BEAT) begin
                        beat_reg  <= '0;
                        state_reg <= DONE;
                    end else begin
                        beat_reg  <= beat_reg + 1'b1;
                    end
                end
                DONE: begin
                    // Hand-off: a waiting word is taken in the same edge the result leaves.
                    if (bus.i_ready) begin
                        if (accept) begin
                            in_reg    <= bus.i_state;
                            beat_reg  <= '0;
                            state_reg <= RUN;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    beat_reg  <= '0;
                end
            endcase
        end
    end
endmodule
